tmds_tx_seq: RTL and testbench

- Symbol-rate sequencer and serializer for the HDMI TX output lanes.
- Accepts parallel 10-bit TMDS symbols for CH_N data channels over a valid/ready handshake and shifts them out one bit per clk.
- Generates the TMDS clock-lane pattern and sequences lane power-up: idle, then warm-up, then run.
- ser_o drives the single-ended inputs of the differential output buffer stage; its width is CH_N+1 (default 4).

---
 rtl/tmds_tx_seq_if.sv | 18 +
 rtl/tmds_tx_seq.sv | 195 +++++++++++++++++++
 tb/tb_tmds_tx_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tmds_tx_seq_if.sv
// rtl/tmds_tx_seq_if.sv - symbol handshake interface for the TMDS TX sequencer
//
// Signals:
//   sym_i      CH_N*SYM_W  packed symbols, channel k at [k*SYM_W +: SYM_W]
//   sym_vld_i  1           symbol valid (driven by the symbol source)
//   sym_rdy_o  1           symbol ready (driven by the sequencer)
// Modports: master = symbol source, slave = tmds_tx_seq.
interface tmds_tx_seq_if #(
  parameter int CH_N  = 3,
  parameter int SYM_W = 10
);
  logic [CH_N*SYM_W-1:0] sym_i;
  logic                  sym_vld_i;
  logic                  sym_rdy_o;

  modport master (output sym_i, output sym_vld_i, input sym_rdy_o);
  modport slave  (input sym_i, input sym_vld_i, output sym_rdy_o);
endinterface

// File: rtl/tmds_tx_seq.sv
// rtl/tmds_tx_seq.sv - TMDS lane sequencer and LSB-first serializer
//
// Ports:
//   clk         bit-rate clock, one serial bit per cycle
//   rst         synchronous active-high reset
//   en_i        link enable (level)
//   tpat_i      test-pattern select (only with TMDS_TX_SEQ_TPAT_EN defined)
//   sym_if      slave side of tmds_tx_seq_if (sym_i / sym_vld_i / sym_rdy_o)
//   ser_o       serial bits: [CH_N-1:0] data lanes, [CH_N] clock lane
//   state_o     FSM state: 0 IDLE, 1 WARM, 2 RUN, 3 STOP
//   underrun_o  one-cycle pulse after a boundary that had to insert filler
// Optional feature macro: TMDS_TX_SEQ_TPAT_EN (alternating test pattern in RUN).
module tmds_tx_seq #(
  parameter int               CH_N     = 3,
  parameter int               SYM_W    = 10,
  parameter int               WARM_SYM = 16,
  parameter logic [SYM_W-1:0] CTRL_SYM = 10'b1101010100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
`ifdef TMDS_TX_SEQ_TPAT_EN
  input  logic          tpat_i,
`endif
  tmds_tx_seq_if.slave  sym_if,
  output logic [CH_N:0] ser_o,
  output logic [1:0]    state_o,
  output logic          underrun_o
);

  localparam logic [15:0]      WARM_LAST = 16'(WARM_SYM - 1);
  localparam logic [SYM_W-1:0] TPAT_SYM  = 10'b1010101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_bit_cnt;
  logic [3:0]       w_bit_cnt_nxt;
  logic [15:0]      r_warm_cnt;
  logic [15:0]      w_warm_cnt_nxt;
  logic             r_sym_rdy;
  logic             w_sym_rdy_nxt;
  logic             r_underrun;
  logic             w_underrun_nxt;
  logic [SYM_W-1:0] r_shreg [CH_N];

  logic w_boundary;
  logic w_run_load;
  logic w_load_ctrl;
  logic w_load_sym;
  logic w_load_tpat;
  logic w_clear;
  logic w_tpat;

`ifdef TMDS_TX_SEQ_TPAT_EN
  assign w_tpat = tpat_i;
`else
  assign w_tpat = 1'b0;
`endif

  // r_sym_rdy carries the boundary timing (set one cycle ahead); en_i and
  // tpat masking are applied on the output so that a handshake seen by the
  // source always matches the load decision made in the same cycle.
  assign sym_if.sym_rdy_o = r_sym_rdy & en_i & ~w_tpat;
  assign state_o          = r_state;
  assign underrun_o       = r_underrun;
  assign w_boundary       = (r_bit_cnt == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_warm_cnt_nxt = r_warm_cnt;
    w_run_load     = 1'b0;
    w_load_ctrl    = 1'b0;
    w_load_sym     = 1'b0;
    w_load_tpat    = 1'b0;
    w_clear        = 1'b0;
    w_underrun_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (en_i) begin
          w_state_nxt    = ST_WARM;
          w_load_ctrl    = 1'b1;
          w_warm_cnt_nxt = '0;
        end
      end
      ST_WARM: begin
        if (w_boundary) begin
          if (!en_i) begin
            w_state_nxt = ST_STOP;
            w_load_ctrl = 1'b1;
          end else if (r_warm_cnt == WARM_LAST) begin
            // Last warm-up boundary doubles as the first RUN load.
            w_state_nxt = ST_RUN;
            w_run_load  = 1'b1;
          end else begin
            w_warm_cnt_nxt = r_warm_cnt + 16'd1;
            w_load_ctrl    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_boundary) begin
          if (!en_i) begin
            w_state_nxt = ST_STOP;
            w_load_ctrl = 1'b1;
          end else begin
            w_run_load = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_boundary) begin
          w_state_nxt = ST_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_clear     = 1'b1;
      end
    endcase

    if (w_run_load) begin
      if (w_tpat) begin
        w_load_tpat = 1'b1;
      end else if (sym_if.sym_vld_i) begin
        w_load_sym = 1'b1;
      end else begin
        w_load_ctrl    = 1'b1;
        w_underrun_nxt = 1'b1;
      end
    end

    w_bit_cnt_nxt = (r_state == ST_IDLE || w_boundary) ? 4'd0 : r_bit_cnt + 4'd1;

    w_sym_rdy_nxt = (r_bit_cnt == 4'd8) &&
                    ((r_state == ST_RUN) ||
                     ((r_state == ST_WARM) && (r_warm_cnt == WARM_LAST)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_warm_cnt <= '0;
      r_sym_rdy  <= 1'b0;
      r_underrun <= 1'b0;
      for (int k = 0; k < CH_N; k++) begin
        r_shreg[k] <= '0;
      end
    end else begin
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_warm_cnt <= w_warm_cnt_nxt;
      r_sym_rdy  <= w_sym_rdy_nxt;
      r_underrun <= w_underrun_nxt;
      for (int k = 0; k < CH_N; k++) begin
        if (w_clear) begin
          r_shreg[k] <= '0;
        end else if (w_load_sym) begin
          r_shreg[k] <= sym_if.sym_i[k*SYM_W +: SYM_W];
        end else if (w_load_tpat) begin
          r_shreg[k] <= TPAT_SYM;
        end else if (w_load_ctrl) begin
          r_shreg[k] <= CTRL_SYM;
        end else if (r_state != ST_IDLE) begin
          r_shreg[k] <= {1'b0, r_shreg[k][SYM_W-1:1]};
        end
      end
    end
  end

  // Clock lane is 1111100000 per symbol while the link is up.
  always_comb begin
    ser_o = '0;
    for (int k = 0; k < CH_N; k++) begin
      ser_o[k] = r_shreg[k][0];
    end
    ser_o[CH_N] = (r_state != ST_IDLE) && (r_bit_cnt < 4'd5);
  end

endmodule

// File: tb/tb_tmds_tx_seq.sv
// tb/tb_tmds_tx_seq.sv - directed self-checking bench for tmds_tx_seq
module tb_tmds_tx_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_i;
  logic       tpat_i;
  logic [3:0] ser_o;
  logic [1:0] state_o;
  logic       underrun_o;

  int n_checks = 0;
  int n_err    = 0;
  int xfers;

  // CTRL_SYM 1101010100 sent LSB first
  bit ctrl_bits [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};

  tmds_tx_seq_if #(.CH_N(3), .SYM_W(10)) sym_if ();

  tmds_tx_seq #(.CH_N(3), .SYM_W(10), .WARM_SYM(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
`ifdef TMDS_TX_SEQ_TPAT_EN
    .tpat_i     (tpat_i),
`endif
    .sym_if     (sym_if),
    .ser_o      (ser_o),
    .state_o    (state_o),
    .underrun_o (underrun_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts on the first WARM cycle; ends stepped into RUN bit 0.
  task automatic check_warm(input string tag);
    for (int i = 0; i < 40; i++) begin
      chk({tag, "_state"}, 32'(state_o), 32'd1);
      chk({tag, "_data"}, 32'(ser_o[2:0]), 32'({3{ctrl_bits[i % 10]}}));
      chk({tag, "_clk"}, 32'(ser_o[3]), 32'((i % 10) < 5));
      chk({tag, "_rdy"}, 32'(sym_if.sym_rdy_o), 32'(i == 39));
      chk({tag, "_urun"}, 32'(underrun_o), 32'd0);
      step();
    end
  endtask

  initial begin
    rst              = 1'b1;
    en_i             = 1'b0;
    tpat_i           = 1'b0;
    sym_if.sym_i     = '0;
    sym_if.sym_vld_i = 1'b0;

    // Reset and idle
    repeat (5) step();
    chk("rst_ser", 32'(ser_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_rdy", 32'(sym_if.sym_rdy_o), 32'd0);
    chk("rst_urun", 32'(underrun_o), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle", 32'({ser_o, state_o, sym_if.sym_rdy_o}), 32'd0);
    end

    // Warm-up, then streaming ch0=3FF ch1=000 ch2=155
    en_i             = 1'b1;
    sym_if.sym_vld_i = 1'b1;
    sym_if.sym_i     = {10'h155, 10'h000, 10'h3FF};
    step();
    check_warm("warm1");

    xfers = 0;
    for (int j = 0; j < 30; j++) begin
      chk("run_state", 32'(state_o), 32'd2);
      chk("run_data", 32'(ser_o[2:0]), 32'({(j % 2 == 0), 1'b0, 1'b1}));
      chk("run_clk", 32'(ser_o[3]), 32'((j % 10) < 5));
      chk("run_rdy", 32'(sym_if.sym_rdy_o), 32'((j % 10) == 9));
      chk("run_urun", 32'(underrun_o), 32'd0);
      if (sym_if.sym_vld_i && sym_if.sym_rdy_o) xfers++;
      step();
    end
    chk("run_xfers", 32'(xfers), 32'd3);

    // Underrun: no valid at the next boundary
    sym_if.sym_vld_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("ur_rdy", 32'(sym_if.sym_rdy_o), 32'(k == 9));
      step();
    end
    sym_if.sym_vld_i = 1'b1;
    sym_if.sym_i     = {10'h0F0, 10'h200, 10'h001};
    for (int u = 0; u < 10; u++) begin
      chk("ur_pulse", 32'(underrun_o), 32'(u == 0));
      chk("ur_data", 32'(ser_o[2:0]), 32'({3{ctrl_bits[u]}}));
      chk("ur_state", 32'(state_o), 32'd2);
      step();
    end
    for (int m = 0; m < 10; m++) begin
      chk("resume_data", 32'(ser_o[2:0]),
          32'({(m >= 4 && m <= 7), (m == 9), (m == 0)}));
      chk("resume_urun", 32'(underrun_o), 32'd0);
      step();
    end

    // Disable at bit_cnt=4: symbol completes, no transfer at the boundary
    repeat (4) step();
    en_i = 1'b0;
    for (int b = 4; b < 10; b++) begin
      chk("dis_state", 32'(state_o), 32'd2);
      chk("dis_data", 32'(ser_o[2:0]), 32'({(b <= 7), (b == 9), 1'b0}));
      chk("dis_rdy", 32'(sym_if.sym_rdy_o), 32'd0);
      step();
    end
    for (int s = 0; s < 10; s++) begin
      chk("stop_state", 32'(state_o), 32'd3);
      chk("stop_data", 32'(ser_o[2:0]), 32'({3{ctrl_bits[s]}}));
      chk("stop_clk", 32'(ser_o[3]), 32'(s < 5));
      chk("stop_rdy", 32'(sym_if.sym_rdy_o), 32'd0);
      chk("stop_urun", 32'(underrun_o), 32'd0);
      if (s == 3) en_i = 1'b1;
      step();
    end
    chk("post_stop_state", 32'(state_o), 32'd0);
    chk("post_stop_ser", 32'(ser_o), 32'd0);

    // Re-enable from IDLE, then reset mid-RUN at bit_cnt=6
    step();
    check_warm("warm2");
    chk("run2_data", 32'(ser_o[2:0]), 32'({1'b0, 1'b0, 1'b1}));
    repeat (6) step();
    chk("run2_state", 32'(state_o), 32'd2);
    rst = 1'b1;
    step();
    chk("midrst_ser", 32'(ser_o), 32'd0);
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_rdy", 32'(sym_if.sym_rdy_o), 32'd0);
    chk("midrst_urun", 32'(underrun_o), 32'd0);
    rst = 1'b0;
    step();
    check_warm("warm3");
    chk("run3_state", 32'(state_o), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
